// File: rtl/sc_mux_adder_n.sv
// N-channel stochastic adder: scaled MUX sum (LFSR select) or saturating OR sum,
// plus a registered nummax sum and a fixed-length window ones counter.
module sc_mux_adder_n #(
  parameter int          NCH      = 4,
  parameter int          MW       = 9,
  parameter int          SEL_W    = $clog2(NCH),
  parameter int          WIN_LOG  = 8,
  parameter logic [15:0] SEED_DEF = 16'hACE1
) (
  input  logic                   clkB,
  input  logic                   rstB_n,
  input  logic                   en,
  input  logic                   mode,
  input  logic                   seed_ld,
  input  logic [15:0]            seed,
  input  logic [NCH-1:0]         bits_in,
  input  logic [NCH*MW-1:0]      nummax_in,
  output logic                   c,
  output logic                   c_valid,
  output logic [MW+SEL_W-1:0]    newnummax,
  output logic [WIN_LOG:0]       count,
  output logic                   count_valid
);

  localparam logic [WIN_LOG-1:0] BIT_LAST = '1;

  logic [15:0]          lfsr_q, lfsr_d;
  logic                 c_q, c_d;
  logic                 c_valid_q, c_valid_d;
  logic [MW+SEL_W-1:0]  newnummax_q, newnummax_d;
  logic [WIN_LOG:0]     ones_q, ones_d;
  logic [WIN_LOG-1:0]   bitcnt_q, bitcnt_d;
  logic [WIN_LOG:0]     count_q, count_d;
  logic                 count_valid_q, count_valid_d;

  logic [SEL_W-1:0]     sel;
  logic                 lfsr_fb;
  logic [WIN_LOG:0]     ones_inc;

  assign sel     = lfsr_q[SEL_W-1:0];
  // Taps 16,14,13,11 in right-shift Fibonacci form.
  assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

  always_comb begin
    lfsr_d = lfsr_q;
    if (seed_ld) begin
      lfsr_d = (seed == 16'h0000) ? SEED_DEF : seed;
    end else if (en) begin
      lfsr_d = {lfsr_fb, lfsr_q[15:1]};
    end
  end

  // The bit uses the pre-update select even on a seed-load cycle.
  always_comb begin
    c_d       = c_q;
    c_valid_d = en;
    if (en) begin
      c_d = mode ? (|bits_in) : bits_in[sel];
    end
  end

  always_comb begin
    newnummax_d = '0;
    for (int i = 0; i < NCH; i++) begin
      newnummax_d = newnummax_d + {{SEL_W{1'b0}}, nummax_in[i*MW +: MW]};
    end
  end

  assign ones_inc = ones_q + {{WIN_LOG{1'b0}}, c_q};

  always_comb begin
    ones_d        = ones_q;
    bitcnt_d      = bitcnt_q;
    count_d       = count_q;
    count_valid_d = 1'b0;
    if (c_valid_q) begin
      bitcnt_d = bitcnt_q + WIN_LOG'(1);
      if (bitcnt_q == BIT_LAST) begin
        count_d       = ones_inc;
        count_valid_d = 1'b1;
        ones_d        = '0;
      end else begin
        ones_d = ones_inc;
      end
    end
  end

  always_ff @(posedge clkB) begin
    if (!rstB_n) begin
      lfsr_q        <= SEED_DEF;
      c_q           <= 1'b0;
      c_valid_q     <= 1'b0;
      newnummax_q   <= '0;
      ones_q        <= '0;
      bitcnt_q      <= '0;
      count_q       <= '0;
      count_valid_q <= 1'b0;
    end else begin
      lfsr_q        <= lfsr_d;
      c_q           <= c_d;
      c_valid_q     <= c_valid_d;
      newnummax_q   <= newnummax_d;
      ones_q        <= ones_d;
      bitcnt_q      <= bitcnt_d;
      count_q       <= count_d;
      count_valid_q <= count_valid_d;
    end
  end

  assign c           = c_q;
  assign c_valid     = c_valid_q;
  assign newnummax   = newnummax_q;
  assign count       = count_q;
  assign count_valid = count_valid_q;

endmodule

// File: tb/tb_sc_mux_adder_n.sv
// Directed bench for sc_mux_adder_n (NCH=4, MW=9, WIN_LOG=8) with a bit-exact LFSR model.
module tb_sc_mux_adder_n;

  logic        clkB;
  logic        rstB_n;
  logic        en;
  logic        mode;
  logic        seed_ld;
  logic [15:0] seed;
  logic [3:0]  bits_in;
  logic [35:0] nummax_in;
  logic        c;
  logic        c_valid;
  logic [10:0] newnummax;
  logic [8:0]  count;
  logic        count_valid;

  int checks = 0;
  int errors = 0;
  int cv_pulses = 0;
  logic [15:0] m;
  int exp_acc;

  sc_mux_adder_n #(.NCH(4), .MW(9), .WIN_LOG(8), .SEED_DEF(16'hACE1)) dut (
    .clkB(clkB), .rstB_n(rstB_n), .en(en), .mode(mode), .seed_ld(seed_ld),
    .seed(seed), .bits_in(bits_in), .nummax_in(nummax_in), .c(c),
    .c_valid(c_valid), .newnummax(newnummax), .count(count),
    .count_valid(count_valid)
  );

  initial begin
    clkB = 1'b0;
    forever #5 clkB = ~clkB;
  end

  always @(negedge clkB) if (count_valid) cv_pulses++;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clkB);
    #1;
  endtask

  task automatic drive_bit(input logic [3:0] b, input logic md);
    logic [3:0] bb;
    bb = b;
    en = 1'b1; bits_in = bb; mode = md;
    exp_acc += md ? int'(|bb) : int'(bb[m[1:0]]);
    m = lfsr_next(m);
    tick();
  endtask

  // Drive 256 valid bits, then check the count pulse two edges after the last bit.
  task automatic run_window(input string tag, input logic [3:0] b, input logic md, output int got);
    int p0;
    exp_acc = 0;
    for (int i = 0; i < 256; i++) drive_bit(b, md);
    p0 = cv_pulses;
    en = 1'b0;
    chk({tag, "_cv_early"}, count_valid, 0);
    tick();
    chk({tag, "_cv"}, count_valid, 1);
    chk({tag, "_count"}, count, exp_acc);
    got = int'(count);
    tick();
    chk({tag, "_cv_one"}, count_valid, 0);
    chk({tag, "_pulses"}, cv_pulses - p0, 1);
  endtask

  initial begin
    int got, got2, p0;
    logic en_prev;
    logic [3:0] b1;
    rstB_n = 1'b0; en = 1'b0; mode = 1'b0; seed_ld = 1'b0; seed = 16'h0;
    bits_in = 4'h0; nummax_in = '0; m = 16'hACE1; exp_acc = 0;
    tick(); tick();
    chk("rst_c", c, 0);
    chk("rst_c_valid", c_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_count_valid", count_valid, 0);
    chk("rst_newnummax", newnummax, 0);
    chk("rst_lfsr", dut.lfsr_q, 16'hACE1);
    rstB_n = 1'b1;
    tick();

    run_window("all_ones", 4'b1111, 1'b0, got);
    chk("all_ones_256", got, 256);
    chk("c_holds", c, 1);
    run_window("all_zero", 4'b0000, 1'b0, got);
    chk("all_zero_0", got, 0);

    seed_ld = 1'b1; seed = 16'hACE1; tick(); seed_ld = 1'b0; m = 16'hACE1;
    chk("seed_load", dut.lfsr_q, 16'hACE1);
    run_window("mux_ch0", 4'b0001, 1'b0, got);
    chk("mux_ch0_range", (got >= 48 && got <= 80), 1);
    seed_ld = 1'b1; seed = 16'h0000; tick(); seed_ld = 1'b0; m = 16'hACE1;
    chk("seed_zero_load", dut.lfsr_q, 16'hACE1);
    run_window("mux_seed0", 4'b0001, 1'b0, got2);
    chk("seed0_same", got2, got);

    run_window("or_0101", 4'b0101, 1'b1, got);
    chk("or_256", got, 256);
    run_window("or_zero", 4'b0000, 1'b1, got);
    chk("or_zero_0", got, 0);

    // Mode switched after bit 128 without restarting the window.
    exp_acc = 0;
    for (int i = 0; i < 256; i++) drive_bit(4'b0001, (i >= 128));
    en = 1'b0; tick();
    chk("mode_mix_cv", count_valid, 1);
    chk("mode_mix_count", count, exp_acc);
    tick();

    nummax_in = {4{9'd511}}; tick();
    chk("nummax_max", newnummax, 2044);
    nummax_in = {9'd0, 9'd0, 9'd0, 9'd1}; tick();
    chk("nummax_one", newnummax, 1);
    nummax_in = {9'd3, 9'd7, 9'd100, 9'd200}; tick();
    chk("nummax_mix", newnummax, 310);

    // en toggles every cycle: half the cycles carry bits.
    p0 = cv_pulses; exp_acc = 0; en_prev = 1'b0;
    b1 = 4'b0011;
    for (int i = 0; i < 512; i++) begin
      if (i % 2 == 0) begin
        drive_bit(b1, 1'b0);
        en_prev = 1'b1;
      end else begin
        en = 1'b0; tick();
        en_prev = 1'b0;
      end
      chk("toggle_c_valid", c_valid, en_prev);
    end
    chk("toggle_lfsr", dut.lfsr_q, m);
    chk("toggle_count", count, exp_acc);
    tick(); tick();
    chk("toggle_pulses", cv_pulses - p0, 1);

    for (int i = 0; i < 100; i++) drive_bit(4'b1111, 1'b0);
    rstB_n = 1'b0; en = 1'b0; tick();
    chk("mid_rst_c", c, 0);
    chk("mid_rst_c_valid", c_valid, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_cv", count_valid, 0);
    chk("mid_rst_nummax", newnummax, 0);
    rstB_n = 1'b1; m = 16'hACE1;
    p0 = cv_pulses;
    exp_acc = 0;
    for (int i = 0; i < 255; i++) drive_bit(4'b1111, 1'b0);
    en = 1'b0; tick(); tick();
    chk("mid_rst_no_early", cv_pulses - p0, 0);
    drive_bit(4'b1111, 1'b0);
    en = 1'b0; tick();
    chk("mid_rst_cv_after", count_valid, 1);
    chk("mid_rst_count_after", count, 256);
    tick();

    // Load and a valid bit in the same cycle: bit uses pre-load select.
    b1 = 4'b0001;
    seed_ld = 1'b1; seed = 16'h1234; en = 1'b1; bits_in = b1; mode = 1'b0;
    exp_acc = int'(b1[m[1:0]]);
    tick();
    seed_ld = 1'b0; en = 1'b0;
    chk("ld_en_lfsr", dut.lfsr_q, 16'h1234);
    chk("ld_en_c_valid", c_valid, 1);
    chk("ld_en_c", c, exp_acc);
    tick();
    chk("ld_en_hold", dut.lfsr_q, 16'h1234);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
